// File: rtl/calc_pkg.sv
// Shared calculator definitions: display status codes, special digit codes,
// print sequencer states and the BCD sizing helper.
package calc_pkg;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [1:0] {
    P_IDLE = 2'b00,
    P_CONV = 2'b01,
    P_SCAN = 2'b10,
    P_FIN  = 2'b11
  } print_state_e;

  // Decimal digits needed to hold any unsigned w-bit value (smallest n with 10^n >= 2^w).
  function automatic int bcd_digits(input int w);
    longint lim;
    longint p;
    int     n;
    lim = 64'sd1 <<< w;
    p   = 64'sd1;
    n   = 32'sd0;
    while (p < lim) begin
      p = p * 64'sd10;
      n = n + 32'sd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/calc_print_ctrl_bin2bcd.sv
// Iterative double-dabble converter: load captures the binary value, each step
// performs one add-3 adjust plus shift; done flags the step that finishes it.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int VAL_W = 27,
  parameter int BCD_W = 36
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [VAL_W-1:0] value,
  output logic [BCD_W-1:0] bcd,
  output logic [BCD_W-1:0] bcd_next,
  output logic             done
);

  localparam int CW = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r;
  logic [CW-1:0]    cnt_r;
  logic [BCD_W-1:0] adj_s;

  // Add-3 correction of every digit >= 5, then shift in the next binary bit.
  always_comb begin
    adj_s = bcd_r;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5) begin
        adj_s[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
      end else begin
        adj_s[4*d +: 4] = bcd_r[4*d +: 4];
      end
    end
    bcd_next = {adj_s[BCD_W-2:0], bin_r[VAL_W-1]};
  end

  // Shift registers and step counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_r <= '0;
      bcd_r <= '0;
      cnt_r <= '0;
    end else if (load) begin
      bin_r <= value;
      bcd_r <= '0;
      cnt_r <= '0;
    end else if (step && (cnt_r != CW'(VAL_W))) begin
      bin_r <= {bin_r[VAL_W-2:0], 1'b0};
      bcd_r <= bcd_next;
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bcd  = bcd_r;
  assign done = step && (cnt_r == CW'(VAL_W - 1));

endmodule

// File: rtl/calc_print_ctrl.sv
// Result print sequencer: converts a latched binary value to BCD, then walks the
// display positions emitting one digit (or blank/error code) per hold window.
module calc_print_ctrl
  import calc_pkg::*;
#(
  parameter int VAL_W    = 27,
  parameter int DIGITS   = 8,
  parameter int HOLD     = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  input  logic             error_in,
  output logic             busy,
  output logic             done,
  output logic             digit_valid,
  output logic [3:0]       data,
  output logic [3:0]       pos,
  output logic [1:0]       status
);

  localparam int BCD_W = 4 * bcd_digits(VAL_W);
  localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;

  print_state_e     state_r, state_s;
  logic             bad_r, bad_s;
  logic [3:0]       pos_cnt_r, pos_cnt_s;
  logic [HW-1:0]    hold_cnt_r, hold_cnt_s;
  logic             load_s, step_s, conv_last_s, ovf_s;
  logic [BCD_W-1:0] bcd_s, bcd_next_s, tail_s;
  logic             busy_s, done_s, dv_s;
  logic [3:0]       data_s, pos_s;
  logic [1:0]       status_s;

  bin2bcd_seq #(.VAL_W(VAL_W), .BCD_W(BCD_W)) u_conv (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .value    (value),
    .bcd      (bcd_s),
    .bcd_next (bcd_next_s),
    .done     (conv_last_s)
  );

  // Overflow looks at the post-shift value so status is correct from the first scan cycle.
  assign ovf_s  = (bcd_next_s >> (4 * DIGITS)) != '0;
  assign tail_s = bcd_s >> {pos_cnt_r, 2'b00};

  // Next-state and next-output decode.
  always_comb begin
    state_s    = state_r;
    bad_s      = bad_r;
    pos_cnt_s  = pos_cnt_r;
    hold_cnt_s = hold_cnt_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    done_s     = 1'b0;
    dv_s       = 1'b0;
    data_s     = data;
    pos_s      = pos;
    status_s   = status;
    case (state_r)
      P_IDLE: begin
        if (start) begin
          load_s     = 1'b1;
          bad_s      = error_in;
          pos_cnt_s  = 4'd0;
          hold_cnt_s = '0;
          if (error_in) begin
            state_s  = P_SCAN;
            status_s = ST_ERR;
          end else begin
            state_s  = P_CONV;
            status_s = ST_BUSY;
          end
        end else begin
          state_s = P_IDLE;
        end
      end
      P_CONV: begin
        step_s = 1'b1;
        if (conv_last_s) begin
          state_s  = P_SCAN;
          bad_s    = ovf_s;
          status_s = ovf_s ? ST_ERR : ST_PRINT;
        end else begin
          state_s = P_CONV;
        end
      end
      P_SCAN: begin
        dv_s  = (hold_cnt_r == '0);
        pos_s = pos_cnt_r;
        // Leading-zero blank: everything from this position upward is zero.
        if (bad_r) begin
          data_s = DIG_ERR;
        end else if ((BLANK_LZ != 0) && (pos_cnt_r != 4'd0) && (tail_s == '0)) begin
          data_s = DIG_BLANK;
        end else begin
          data_s = tail_s[3:0];
        end
        if (hold_cnt_r == HW'(HOLD - 1)) begin
          hold_cnt_s = '0;
          if (pos_cnt_r == 4'(DIGITS - 1)) begin
            state_s = P_FIN;
          end else begin
            pos_cnt_s = pos_cnt_r + 4'd1;
          end
        end else begin
          hold_cnt_s = hold_cnt_r + HW'(1);
        end
      end
      P_FIN: begin
        state_s  = P_IDLE;
        done_s   = 1'b1;
        pos_s    = 4'd0;
        status_s = bad_r ? ST_ERR : ST_READY;
      end
      default: begin
        state_s = P_IDLE;
      end
    endcase
    busy_s = (state_s != P_IDLE);
  end

  // State, counters and registered display outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= P_IDLE;
      bad_r       <= 1'b0;
      pos_cnt_r   <= 4'd0;
      hold_cnt_r  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      digit_valid <= 1'b0;
      data        <= 4'd0;
      pos         <= 4'd0;
      status      <= ST_READY;
    end else begin
      state_r     <= state_s;
      bad_r       <= bad_s;
      pos_cnt_r   <= pos_cnt_s;
      hold_cnt_r  <= hold_cnt_s;
      busy        <= busy_s;
      done        <= done_s;
      digit_valid <= dv_s;
      data        <= data_s;
      pos         <= pos_s;
      status      <= status_s;
    end
  end

endmodule

// File: tb/tb_calc_print_ctrl.sv
// Bench for calc_print_ctrl: two instances (HOLD=1 and HOLD=3) checked every
// cycle against a timeline model derived from accept cycle, value and flags.
module tb_calc_print_ctrl;

  localparam int VAL_W  = 27;
  localparam int DIGITS = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start [2] = '{1'b0, 1'b0};
  logic [VAL_W-1:0] value = '0;
  logic             error_in = 1'b0;

  logic       busy_o [2];
  logic       done_o [2];
  logic       dv_o   [2];
  logic [3:0] data_o [2];
  logic [3:0] pos_o  [2];
  logic [1:0] status_o [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  calc_print_ctrl #(.VAL_W(VAL_W), .DIGITS(DIGITS), .HOLD(1), .BLANK_LZ(1)) u0 (
    .clock(clock), .reset(reset), .start(start[0]), .value(value), .error_in(error_in),
    .busy(busy_o[0]), .done(done_o[0]), .digit_valid(dv_o[0]), .data(data_o[0]),
    .pos(pos_o[0]), .status(status_o[0]));

  calc_print_ctrl #(.VAL_W(VAL_W), .DIGITS(DIGITS), .HOLD(3), .BLANK_LZ(1)) u1 (
    .clock(clock), .reset(reset), .start(start[1]), .value(value), .error_in(error_in),
    .busy(busy_o[1]), .done(done_o[1]), .digit_valid(dv_o[1]), .data(data_o[1]),
    .pos(pos_o[1]), .status(status_o[1]));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Model state per instance.
  bit         job      [2] = '{1'b0, 1'b0};
  int         t0       [2];
  int         hold_n   [2] = '{1, 3};
  bit         bad_m    [2];
  bit         errin_m  [2];
  longint     val_m    [2];
  logic [3:0] pre_data [2] = '{4'd0, 4'd0};
  int         acc_cyc  [2];
  int         first_dv [2];
  int         done_cnt [2] = '{0, 0};
  logic [3:0] cap0 [$];
  logic [3:0] cap1 [$];

  logic       eb, ed, ev, inwin;
  logic [3:0] edat, epos;
  logic [1:0] est;
  int         fdv, dat, k;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] digit_exp(input longint v, input int kk, input bit bad);
    longint p = 1;
    for (int j = 0; j < kk; j++) p = p * 10;
    if (bad) return 4'hE;
    if (kk > 0 && (v / p) == 0) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  function automatic longint max_plus1();
    longint p = 1;
    for (int j = 0; j < DIGITS; j++) p = p * 10;
    return p;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        job[i] = 1'b0; pre_data[i] = 4'd0;
        eb = 1'b0; ed = 1'b0; ev = 1'b0; edat = 4'd0; epos = 4'd0; est = 2'b10;
      end else if (!job[i]) begin
        eb = 1'b0; ed = 1'b0; ev = 1'b0; edat = pre_data[i]; epos = 4'd0; est = 2'b10;
      end else begin
        fdv   = t0[i] + (errin_m[i] ? 1 : VAL_W + 1);
        dat   = fdv + DIGITS * hold_n[i];
        eb    = cyc < dat;
        ed    = cyc == dat;
        inwin = (cyc >= fdv) && (cyc < dat);
        k     = inwin ? (cyc - fdv) / hold_n[i] : 0;
        ev    = inwin && ((cyc - fdv) % hold_n[i] == 0);
        epos  = inwin ? 4'(k) : 4'd0;
        if (inwin) edat = digit_exp(val_m[i], k, bad_m[i]);
        else if (cyc < fdv) edat = pre_data[i];
        else edat = digit_exp(val_m[i], DIGITS - 1, bad_m[i]);
        if (cyc < fdv - 1) est = 2'b01;
        else if (cyc < dat) est = bad_m[i] ? 2'b00 : 2'b11;
        else est = bad_m[i] ? 2'b00 : 2'b10;
      end
      chk("busy", i, 32'(busy_o[i]), 32'(eb));
      chk("done", i, 32'(done_o[i]), 32'(ed));
      chk("digit_valid", i, 32'(dv_o[i]), 32'(ev));
      chk("data", i, 32'(data_o[i]), 32'(edat));
      chk("pos", i, 32'(pos_o[i]), 32'(epos));
      chk("status", i, 32'(status_o[i]), 32'(est));
      if (dv_o[i]) begin
        if (i == 0) begin
          if (cap0.size() == 0) first_dv[0] = cyc;
          cap0.push_back(data_o[0]);
        end else begin
          if (cap1.size() == 0) first_dv[1] = cyc;
          cap1.push_back(data_o[1]);
        end
      end
      if (done_o[i]) done_cnt[i]++;
      if (!reset && start[i] && !eb) begin
        pre_data[i] = edat;
        job[i]      = 1'b1;
        t0[i]       = cyc + 1;
        acc_cyc[i]  = cyc + 1;
        val_m[i]    = longint'(value);
        errin_m[i]  = error_in;
        bad_m[i]    = error_in || (longint'(value) >= max_plus1());
      end
    end
  end

  task automatic clear_caps(input int i);
    if (i == 0) cap0.delete(); else cap1.delete();
    done_cnt[i] = 0;
  endtask

  task automatic kick(input int i, input logic [VAL_W-1:0] v, input logic e);
    @(posedge clock); #2;
    clear_caps(i);
    value = v; error_in = e; start[i] = 1'b1;
    @(posedge clock); #2;
    start[i] = 1'b0; error_in = 1'b0;
  endtask

  task automatic wait_dv(input int i);
    int n = 0;
    while (!dv_o[i] && n < 200) begin @(posedge clock); #2; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_dv[%0d] timeout got=none want=digit_valid", i);
    end
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (!done_o[i] && n < 300) begin @(posedge clock); #2; n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL wait_done[%0d] timeout got=none want=done", i);
    end
    repeat (2) @(posedge clock);
    #2;
  endtask

  task automatic print(input int i, input logic [VAL_W-1:0] v, input logic e);
    kick(i, v, e);
    wait_done(i);
  endtask

  logic [3:0] lit1234 [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF};

  initial begin
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);

    // 1: 1234
    print(0, 27'd1234, 1'b0);
    chk("lit_cnt_1234", 0, 32'(cap0.size()), 32'd8);
    for (int j = 0; j < 8 && j < cap0.size(); j++) chk("lit_dig_1234", 0, 32'(cap0[j]), 32'(lit1234[j]));
    chk("lit_latency", 0, 32'(first_dv[0] - acc_cyc[0]), 32'd28);
    chk("lit_done_once", 0, 32'(done_cnt[0]), 32'd1);
    chk("lit_status_ready", 0, 32'(status_o[0]), 32'd2);

    // 2: zero
    print(0, 27'd0, 1'b0);
    if (cap0.size() == 8) begin
      chk("lit_zero_p0", 0, 32'(cap0[0]), 32'h0);
      chk("lit_zero_p7", 0, 32'(cap0[7]), 32'hF);
    end else chk("lit_zero_cnt", 0, 32'(cap0.size()), 32'd8);

    // 3: max and overflow
    print(0, 27'd99_999_999, 1'b0);
    if (cap0.size() == 8) chk("lit_max_p7", 0, 32'(cap0[7]), 32'h9);
    else chk("lit_max_cnt", 0, 32'(cap0.size()), 32'd8);
    print(0, 27'd100_000_000, 1'b0);
    if (cap0.size() == 8) chk("lit_ovf_p0", 0, 32'(cap0[0]), 32'hE);
    else chk("lit_ovf_cnt", 0, 32'(cap0.size()), 32'd8);
    chk("lit_ovf_status", 0, 32'(status_o[0]), 32'd0);

    // 4: error input
    print(0, 27'd5, 1'b1);
    chk("lit_err_latency", 0, 32'(first_dv[0] - acc_cyc[0]), 32'd1);
    if (cap0.size() == 8) chk("lit_err_p3", 0, 32'(cap0[3]), 32'hE);
    else chk("lit_err_cnt", 0, 32'(cap0.size()), 32'd8);

    // 5: start during scan ignored
    kick(0, 27'd42, 1'b0);
    wait_dv(0);
    value = 27'd7; start[0] = 1'b1;
    @(posedge clock); #2;
    start[0] = 1'b0;
    wait_done(0);
    if (cap0.size() == 8) begin
      chk("lit_ign_p0", 0, 32'(cap0[0]), 32'h2);
      chk("lit_ign_p1", 0, 32'(cap0[1]), 32'h4);
    end else chk("lit_ign_cnt", 0, 32'(cap0.size()), 32'd8);
    chk("lit_ign_done", 0, 32'(done_cnt[0]), 32'd1);

    // 6a: reset mid-conversion
    kick(0, 27'd1234, 1'b0);
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    repeat (40) @(posedge clock);
    chk("lit_rst_conv_done", 0, 32'(done_cnt[0]), 32'd0);

    // 6b: reset mid-scan
    kick(0, 27'd1234, 1'b0);
    wait_dv(0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock); #2 reset = 1'b0;
    repeat (20) @(posedge clock);
    chk("lit_rst_scan_done", 0, 32'(done_cnt[0]), 32'd0);

    // 6c: HOLD=3 instance
    print(1, 27'd1234, 1'b0);
    chk("lit_h3_cnt", 1, 32'(cap1.size()), 32'd8);
    for (int j = 0; j < 8 && j < cap1.size(); j++) chk("lit_h3_dig", 1, 32'(cap1[j]), 32'(lit1234[j]));
    chk("lit_h3_done", 1, 32'(done_cnt[1]), 32'd1);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
